// File: rtl/rcv_fifo_buffer.sv
// Receive-side show-ahead FIFO with wrap-toggled head/tail pointers, occupancy count,
// sticky overflow/underflow flags and a synchronous clear.
module rcv_fifo_buffer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 3,
    localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count,
    output logic [PTR_W-1:0]      head_ptr,
    output logic [PTR_W-1:0]      tail_ptr,
    output logic                  overflow_err,
    output logic                  underflow_err
);

    localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  head_tog;
    logic                  tail_tog;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [PTR_W-1:0]      head_nxt;
    logic [PTR_W-1:0]      tail_nxt;
    logic                  head_wrap;
    logic                  tail_wrap;

    // Full/empty come only from registered pointer state, never from the requests.
    always_comb begin
        empty = (head_ptr == tail_ptr) && (head_tog == tail_tog);
        full  = (head_ptr == tail_ptr) && (head_tog != tail_tog);
    end

    always_comb begin
        wr_acc    = wr_en && !full;
        rd_acc    = rd_en && !empty;
        head_wrap = (head_ptr == LAST_ROW);
        tail_wrap = (tail_ptr == LAST_ROW);
        head_nxt  = head_wrap ? '0 : head_ptr + PTR_W'(1);
        tail_nxt  = tail_wrap ? '0 : tail_ptr + PTR_W'(1);
    end

    // Pointer, toggle, occupancy and error-flag state; clear outranks any request.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            head_ptr      <= '0;
            tail_ptr      <= '0;
            head_tog      <= 1'b0;
            tail_tog      <= 1'b0;
            count         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else if (clear) begin
            head_ptr      <= '0;
            tail_ptr      <= '0;
            head_tog      <= 1'b0;
            tail_tog      <= 1'b0;
            count         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (wr_acc) begin
                head_ptr <= head_nxt;
                if (head_wrap) head_tog <= ~head_tog;
            end
            if (rd_acc) begin
                tail_ptr <= tail_nxt;
                if (tail_wrap) tail_tog <= ~tail_tog;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (wr_en && full)  overflow_err  <= 1'b1;
            if (rd_en && empty) underflow_err <= 1'b1;
        end
    end

    // Storage is not reset; a flushed FIFO simply reports empty.
    always_ff @(posedge clk) begin
        if (!clear && wr_acc) mem[head_ptr] <= wr_data;
    end

    assign rd_data = mem[tail_ptr];

endmodule

// File: tb/tb_rcv_fifo_buffer.sv
// Randomized + directed bench for rcv_fifo_buffer against a queue-based reference model.
module tb_rcv_fifo_buffer;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned PW    = 2;
    localparam int unsigned CW    = 2;

    logic          clk;
    logic          n_rst;
    logic          clear;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic          overflow_err;
    logic          underflow_err;

    rcv_fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .head_ptr     (head_ptr),
        .tail_ptr     (tail_ptr),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents as a queue, pointers as total transfers modulo DEPTH.
    logic [DW-1:0] q[$];
    int            m_wr_total;
    int            m_rd_total;
    bit            m_ovf;
    bit            m_udf;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        q.delete();
        m_wr_total = 0;
        m_rd_total = 0;
        m_ovf      = 1'b0;
        m_udf      = 1'b0;
    endtask

    task automatic model_update(input bit clr, input bit we, input logic [DW-1:0] wd, input bit re);
        bit is_full;
        bit is_empty;
        if (clr) begin
            model_reset();
        end else begin
            is_full  = (q.size() == DEPTH);
            is_empty = (q.size() == 0);
            if (we && is_full)  m_ovf = 1'b1;
            if (re && is_empty) m_udf = 1'b1;
            if (re && !is_empty) begin
                void'(q.pop_front());
                m_rd_total++;
            end
            if (we && !is_full) begin
                q.push_back(wd);
                m_wr_total++;
            end
        end
    endtask

    task automatic check_all();
        check_eq("empty", 32'(empty), 32'(q.size() == 0));
        check_eq("full", 32'(full), 32'(q.size() == DEPTH));
        check_eq("count", 32'(count), 32'(q.size()));
        check_eq("head_ptr", 32'(head_ptr), 32'(m_wr_total % DEPTH));
        check_eq("tail_ptr", 32'(tail_ptr), 32'(m_rd_total % DEPTH));
        check_eq("overflow_err", 32'(overflow_err), 32'(m_ovf));
        check_eq("underflow_err", 32'(underflow_err), 32'(m_udf));
        if (q.size() != 0) check_eq("rd_data", 32'(rd_data), 32'(q[0]));
    endtask

    // Apply one cycle of requests, advance the model across the edge, then compare.
    task automatic step(input bit clr, input bit we, input logic [DW-1:0] wd, input bit re);
        clear   = clr;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        model_update(clr, we, wd, re);
        #1;
        clear = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_all();
    endtask

    initial begin
        n_rst   = 1'b0;
        clear   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        check_all();

        // Fill to full, then reject a write while full
        step(1'b0, 1'b1, 8'hA1, 1'b0);
        step(1'b0, 1'b1, 8'hB2, 1'b0);
        step(1'b0, 1'b1, 8'hC3, 1'b0);
        check_eq("t1_rd_data", 32'(rd_data), 32'h0000_00A1);
        step(1'b0, 1'b1, 8'hD4, 1'b0);
        check_eq("t2_ovf", 32'(overflow_err), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        check_eq("t2_empty", 32'(empty), 32'd1);

        // Simultaneous requests at empty and at full
        step(1'b0, 1'b1, 8'h55, 1'b1);
        check_eq("t3_rd_data", 32'(rd_data), 32'h0000_0055);
        step(1'b0, 1'b1, 8'h66, 1'b0);
        step(1'b0, 1'b1, 8'h77, 1'b0);
        step(1'b0, 1'b1, 8'h88, 1'b1);
        check_eq("t3_count", 32'(count), 32'd2);

        // Steady stream at occupancy one
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b1);
        check_eq("t4_rd_data", 32'(rd_data), 32'h0000_0019);

        // Clear with a coincident write: write dropped, flags cleared
        step(1'b0, 1'b1, 8'h99, 1'b0);
        step(1'b1, 1'b1, 8'hEE, 1'b0);
        check_eq("t5_count", 32'(count), 32'd0);

        // Async reset mid-cycle with two entries held
        step(1'b0, 1'b1, 8'h31, 1'b0);
        step(1'b0, 1'b1, 8'h32, 1'b0);
        #3;
        n_rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        step(1'b0, 1'b1, 8'h5A, 1'b0);
        check_eq("t6_rd_data", 32'(rd_data), 32'h0000_005A);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
                 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rcv_fifo_buffer.md
Name: rcv_fifo_buffer

Overview:
Receive-side FIFO buffer that sits downstream of the receive datapath and upstream of the consumer interface. It holds DEPTH words. A head (write) pointer and a tail (read) pointer each carry a wrap toggle bit, and full/empty are derived from the pointers plus toggles. The block also provides occupancy count, sticky overflow/underflow error flags, and a synchronous clear. Read data is show-ahead: the word at the tail is always presented on rd_data.

Parameters:
DATA_WIDTH, 8, width of each stored word
DEPTH, 3, number of entries; pointers run 0..DEPTH-1 and then wrap; must be >= 2

Ports:
clk  input  1  system clock, all state updates on rising edge
n_rst  input  1  asynchronous active-low reset
clear  input  1  synchronous flush of pointers, toggles and error flags
wr_en  input  1  write request; accepted only when not full
wr_data  input  DATA_WIDTH  word to store on an accepted write
rd_en  input  1  read/pop request; accepted only when not empty
rd_data  output  DATA_WIDTH  word at tail (show-ahead); content unspecified when empty
full  output  1  DEPTH entries held
empty  output  1  zero entries held
count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
head_ptr  output  max(1,$clog2(DEPTH))  next write row
tail_ptr  output  max(1,$clog2(DEPTH))  current read row
overflow_err  output  1  sticky: a write was attempted while full
underflow_err  output  1  sticky: a read was attempted while empty

Behaviour:
- Reset (n_rst=0, async): head_ptr=0, tail_ptr=0, head_tog=0, tail_tog=0, count=0, overflow_err=0, underflow_err=0. Outputs are therefore empty=1, full=0. Storage array is not reset.
- empty = (head_ptr==tail_ptr) && (head_tog==tail_tog). full = (head_ptr==tail_ptr) && (head_tog!=tail_tog). Both are combinational from registered state and are never 1 together.
- Accepted write: wr_en && !full. On the clock edge, mem[head_ptr] <= wr_data. head_ptr increments; when head_ptr==DEPTH-1 it returns to 0 and head_tog inverts.
- Accepted read: rd_en && !empty. tail_ptr increments with the same wrap rule, and tail_tog inverts on wrap. rd_data = mem[tail_ptr] combinationally, so the next word appears the cycle after the pop.
- Full/empty are evaluated on pre-edge state when write and read coincide:
  - Not full and not empty: both are accepted, count is unchanged, and pointers/toggles advance independently.
  - Full: the read is accepted and the write is rejected (overflow_err set). Result count=DEPTH-1.
  - Empty: the write is accepted and the read is rejected (underflow_err set). Result count=1. There is no bypass; rd_data is valid from the next cycle.
- count: +1 on write only, -1 on read only, unchanged on both or neither. It must always equal the occupancy implied by the pointers and toggles.
- Error flags: overflow_err <= 1 when wr_en && full; underflow_err <= 1 when rd_en && empty. Both hold until clear or reset.
- clear (sync, highest priority over wr_en/rd_en): next state equals the reset state, and any write or read in that cycle is ignored. Memory contents are untouched.
- Reset asserted mid-operation: the block returns to the reset state immediately. Stored words are lost logically because empty=1.
- No combinational path from wr_en/rd_en to full/empty/count.

Test Plan:
1. Reset, then 3 writes of 0xA1, 0xB2, 0xC3 on consecutive cycles -> count 1,2,3; full=1 after the third edge; head_ptr=0, head_tog=1; rd_data=0xA1.
2. From full, one write of 0xD4 -> rejected; overflow_err=1; count=3. Then 3 reads -> rd_data sequence 0xA1, 0xB2, 0xC3; empty=1; tail_ptr=0, tail_tog=1.
3. From empty, wr_en=rd_en=1 with 0x55 -> count=1, underflow_err=1, rd_data=0x55 the next cycle. From full, wr_en=rd_en=1 -> count=2, overflow_err=1.
4. Steady stream: 10 cycles of simultaneous write/read at count=1 with incrementing data 0x10..0x19 -> count stays 1; rd_data lags wr_data by exactly one word; pointers wrap correctly through 2->0 multiple times.
5. With 2 entries and both error flags set, pulse clear together with wr_en=1 -> next cycle empty=1, count=0, both flags 0, head_ptr=tail_ptr=0; the write is dropped.
6. Assert n_rst low asynchronously mid-cycle while count=2 -> outputs go to reset values before the next clk edge; after release, the first write/read round-trip returns the correct data.
